// File: rtl/psub_serial.sv
// Multi-cycle lane-parallel saturating subtractor: Diff = A - B per two's-complement lane, one lane per cycle.
// Optional per-lane saturation status port is enabled by defining PSUB_LANE_STATUS_EN.
module psub_serial #(
   parameter  int LANES  = 4,
   parameter  int LANE_W = 4,
   localparam int DATA_W = LANES * LANE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] Diff,
   output logic              Ovfl,
`ifdef PSUB_LANE_STATUS_EN
   output logic [LANES-1:0]  ovfl_lanes,
`endif
   output logic [1:0]        dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and both depend on state alone.

   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_q, last_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   diff_q, diff_d;
   logic                ovfl_q, ovfl_d;
`ifdef PSUB_LANE_STATUS_EN
   logic [LANES-1:0]    lanes_q, lanes_d;
`endif

   int unsigned         lane_base;
   logic [LANE_W-1:0]   lane_a;
   logic [LANE_W-1:0]   lane_b;
   logic [LANE_W-1:0]   lane_r;
   logic [LANE_W-1:0]   lane_sat;
   logic                lane_pos;
   logic                lane_neg;

   // Shared lane adder: r = a + ~b + 1, saturated from the three sign bits.
   always_comb begin
      lane_base = int'(cnt_q) * LANE_W;
      lane_a    = a_q[lane_base +: LANE_W];
      lane_b    = b_q[lane_base +: LANE_W];
      lane_r    = lane_a + ~lane_b + LANE_W'(1);
      lane_pos  = ~lane_a[LANE_W-1] &  lane_b[LANE_W-1] &  lane_r[LANE_W-1];
      lane_neg  =  lane_a[LANE_W-1] & ~lane_b[LANE_W-1] & ~lane_r[LANE_W-1];
      if (lane_pos) begin
         lane_sat = {1'b0, {(LANE_W-1){1'b1}}};
      end else if (lane_neg) begin
         lane_sat = {1'b1, {(LANE_W-1){1'b0}}};
      end else begin
         lane_sat = lane_r;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      ovfl_d  = ovfl_q;
`ifdef PSUB_LANE_STATUS_EN
      lanes_d = lanes_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               diff_d  = '0;
               ovfl_d  = 1'b0;
               cnt_d   = '0;
               last_d  = 1'b0;
`ifdef PSUB_LANE_STATUS_EN
               lanes_d = '0;
`endif
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // After the last lane is written, one more CALC cycle is spent before DONE.
            if (last_q) begin
               last_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               diff_d[lane_base +: LANE_W] = lane_sat;
               ovfl_d = ovfl_q | lane_pos | lane_neg;
`ifdef PSUB_LANE_STATUS_EN
               lanes_d[cnt_q] = lane_pos | lane_neg;
`endif
               if (cnt_q == LAST_LANE) begin
                  cnt_d  = '0;
                  last_d = 1'b1;
               end else begin
                  cnt_d  = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         ovfl_q  <= 1'b0;
`ifdef PSUB_LANE_STATUS_EN
         lanes_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         ovfl_q  <= ovfl_d;
`ifdef PSUB_LANE_STATUS_EN
         lanes_q <= lanes_d;
`endif
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign Diff       = diff_q;
   assign Ovfl       = ovfl_q;
`ifdef PSUB_LANE_STATUS_EN
   assign ovfl_lanes = lanes_q;
`endif
   assign dbg_state  = state_q;

endmodule
